payment_window_ctrl: RTL and testbench

//  Payment-window countdown for the ticket booking flow. Sits downstream of the 1-second tick timer:
//  - drives the timer's enable input;
//  - consumes its done pulse as the tick input;
//  - counts down the seconds the passenger has to pay.

---
 rtl/metro_pkg.sv | 17 +
 rtl/rise_edge_det.sv | 19 +
 rtl/payment_window_ctrl.sv | 121 ++++++++++++
 tb/tb_payment_window_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/metro_pkg.sv
// Shared metro ticket-machine definitions.
// Window state encoding and default second constants.
package metro_pkg;

  typedef enum logic [1:0] {
    PW_IDLE,
    PW_COUNT,
    PW_WARN,
    PW_EXPIRED
  } pwin_state_t;

  localparam int unsigned PW_WINDOW_SEC = 60;
  localparam int unsigned PW_WARN_SEC   = 10;
  localparam int unsigned PW_EXTEND_SEC = 30;
  localparam int unsigned PW_MAX_SEC    = 120;

endpackage

// File: rtl/rise_edge_det.sv
// Rising-edge detector.
// rise is combinational from d against its registered copy.
module rise_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) d_q <= 1'b0;
    else        d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/payment_window_ctrl.sv
// Payment-window countdown driven by the 1-second timer.
// Coins extend the window; reports expiry or payment once.
module payment_window_ctrl
  import metro_pkg::*;
#(
  parameter int unsigned WINDOW_SEC = PW_WINDOW_SEC,
  parameter int unsigned WARN_SEC   = PW_WARN_SEC,
  parameter int unsigned EXTEND_SEC = PW_EXTEND_SEC,
  parameter int unsigned MAX_SEC    = PW_MAX_SEC,
  localparam int SW = $clog2(MAX_SEC + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          coin_evt,
  input  logic          pay_ok,
  input  logic          cancel,
  input  logic          tick,
  output logic          tick_en,
  output logic          busy,
  output logic          warn,
  output logic [SW-1:0] secs_left,
  output logic          expired,
  output logic          paid
);

  if (!(WARN_SEC >= 1 && WARN_SEC < WINDOW_SEC &&
        WINDOW_SEC <= MAX_SEC && EXTEND_SEC >= 1))
  begin : g_bad_params
    $error("payment_window_ctrl: illegal parameters");
  end

  localparam logic [SW:0] WIN_W  = WINDOW_SEC[SW:0];
  localparam logic [SW:0] WARN_W = WARN_SEC[SW:0];
  localparam logic [SW:0] MAX_W  = MAX_SEC[SW:0];
  // Clamp the increment so the sum can never overflow SW+1 bits.
  localparam logic [SW:0] EXT_W  =
    (EXTEND_SEC > MAX_SEC) ? MAX_SEC[SW:0] : EXTEND_SEC[SW:0];

  pwin_state_t state_q, state_n;
  logic [SW-1:0] secs_n;
  logic paid_n;
  logic tick_rise, tk;
  logic [SW:0] cur_w, dec_w, sum_w, ext_w;

  rise_edge_det u_tick_det (
    .clk   (clk),
    .reset (reset),
    .d     (tick),
    .rise  (tick_rise)
  );

  assign tk = tick_rise & tick_en;

  function automatic pwin_state_t zone(input logic [SW:0] v);
    return (v <= WARN_W) ? PW_WARN : PW_COUNT;
  endfunction

  always_comb begin
    cur_w   = {1'b0, secs_left};
    dec_w   = cur_w - {{SW{1'b0}}, tk};
    sum_w   = dec_w + EXT_W;
    ext_w   = (sum_w > MAX_W) ? MAX_W : sum_w;
    state_n = state_q;
    secs_n  = secs_left;
    paid_n  = 1'b0;
    unique case (state_q)
      PW_IDLE: begin
        if (start) begin
          state_n = PW_COUNT;
          secs_n  = WIN_W[SW-1:0];
        end
      end
      PW_COUNT, PW_WARN: begin
        if (cancel) begin
          state_n = PW_IDLE;
          secs_n  = '0;
        end else if (pay_ok) begin
          state_n = PW_IDLE;
          secs_n  = '0;
          paid_n  = 1'b1;
        end else if (coin_evt) begin
          state_n = zone(ext_w);
          secs_n  = ext_w[SW-1:0];
        end else if (tk) begin
          state_n = (dec_w == '0) ? PW_EXPIRED : zone(dec_w);
          secs_n  = dec_w[SW-1:0];
        end
      end
      PW_EXPIRED: begin
        state_n = PW_IDLE;
        secs_n  = '0;
      end
      default: begin
        state_n = PW_IDLE;
        secs_n  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= PW_IDLE;
      secs_left <= '0;
      tick_en   <= 1'b0;
      busy      <= 1'b0;
      warn      <= 1'b0;
      expired   <= 1'b0;
      paid      <= 1'b0;
    end else begin
      state_q   <= state_n;
      secs_left <= secs_n;
      tick_en   <= (state_n == PW_COUNT) || (state_n == PW_WARN);
      busy      <= (state_n == PW_COUNT) || (state_n == PW_WARN);
      warn      <= (state_n == PW_WARN);
      expired   <= (state_n == PW_EXPIRED);
      paid      <= paid_n;
    end
  end

endmodule

// File: tb/tb_payment_window_ctrl.sv
// Directed bench for payment_window_ctrl.
// Small window (5/2/3/8) with a 4-clock tick pulser.
module tb_payment_window_ctrl;

  localparam int SW = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic coin_evt = 1'b0;
  logic pay_ok = 1'b0;
  logic cancel = 1'b0;
  logic tick;
  logic tick_en, busy, warn, expired, paid;
  logic [SW-1:0] secs_left;

  logic auto_en = 1'b0;
  logic man_tick = 1'b0;
  logic tick_p = 1'b0;
  int pcnt = 0;

  int tests = 0;
  int fails = 0;

  payment_window_ctrl #(
    .WINDOW_SEC (5),
    .WARN_SEC   (2),
    .EXTEND_SEC (3),
    .MAX_SEC    (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .coin_evt  (coin_evt),
    .pay_ok    (pay_ok),
    .cancel    (cancel),
    .tick      (tick),
    .tick_en   (tick_en),
    .busy      (busy),
    .warn      (warn),
    .secs_left (secs_left),
    .expired   (expired),
    .paid      (paid)
  );

  always #5 clk = ~clk;

  assign tick = auto_en ? tick_p : man_tick;

  // Stand-in timer: 1-cycle done every 4 enabled clocks, paused otherwise.
  always @(negedge clk) begin
    if (auto_en && tick_en) begin
      if (pcnt == 3) begin
        tick_p <= 1'b1;
        pcnt   <= 0;
      end else begin
        tick_p <= 1'b0;
        pcnt   <= pcnt + 1;
      end
    end else begin
      tick_p <= 1'b0;
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_tick_en"}, 32'(tick_en), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_warn"}, 32'(warn), 0);
    chk({tag, "_secs"}, 32'(secs_left), 0);
    chk({tag, "_expired"}, 32'(expired), 0);
    chk({tag, "_paid"}, 32'(paid), 0);
  endtask

  task automatic mtick();
    man_tick = 1'b1;
    cyc();
    man_tick = 1'b0;
    cyc();
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    int exp_v;
    logic [SW-1:0] prev;
    bit done;

    repeat (3) cyc();
    chk_idle("rst");
    reset = 1'b1;
    cyc();

    // 1: reset in the middle of a window
    do_start();
    auto_en = 1'b1;
    for (int i = 0; i < 100 && secs_left != 3; i++) cyc();
    chk("t1_reach3", 32'(secs_left), 3);
    reset = 1'b0;
    #1;
    chk_idle("t1_async");
    auto_en = 1'b0;
    cyc();
    reset = 1'b1;
    mtick();
    chk_idle("t1_after");

    // 2: full countdown to expiry
    do_start();
    chk("t2_secs0", 32'(secs_left), 5);
    chk("t2_busy", 32'(busy), 1);
    chk("t2_tick_en", 32'(tick_en), 1);
    chk("t2_warn0", 32'(warn), 0);
    auto_en = 1'b1;
    exp_v = 4;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      prev = secs_left;
      cyc();
      if (expired) begin
        chk("t2_prev1", 32'(prev), 1);
        chk("t2_exp_secs", 32'(secs_left), 0);
        chk("t2_exp_tick_en", 32'(tick_en), 0);
        chk("t2_exp_busy", 32'(busy), 0);
        done = 1;
      end else if (secs_left != prev) begin
        chk("t2_step", 32'(secs_left), 32'(exp_v));
        chk("t2_warn", 32'(warn), (exp_v <= 2) ? 1 : 0);
        exp_v--;
      end
    end
    chk("t2_expired_seen", 32'(done), 1);
    cyc();
    chk("t2_exp_once", 32'(expired), 0);
    chk("t2_idle_busy", 32'(busy), 0);
    auto_en = 1'b0;

    // 3: coins extend and saturate
    do_start();
    auto_en = 1'b1;
    for (int i = 0; i < 100 && secs_left != 2; i++) cyc();
    auto_en = 1'b0;
    chk("t3_at2", 32'(secs_left), 2);
    chk("t3_warn1", 32'(warn), 1);
    coin_evt = 1'b1;
    cyc();
    coin_evt = 1'b0;
    chk("t3_coin1", 32'(secs_left), 5);
    chk("t3_warn_drop", 32'(warn), 0);
    for (int k = 0; k < 3; k++) begin
      coin_evt = 1'b1;
      cyc();
      coin_evt = 1'b0;
      chk("t3_sat", 32'(secs_left), 8);
    end
    cancel = 1'b1;
    cyc();
    cancel = 1'b0;
    chk_idle("t3_cancel");

    // 4: coin on the final tick rescues the window
    do_start();
    repeat (4) mtick();
    chk("t4_at1", 32'(secs_left), 1);
    chk("t4_warn1", 32'(warn), 1);
    man_tick = 1'b1;
    coin_evt = 1'b1;
    cyc();
    man_tick = 1'b0;
    coin_evt = 1'b0;
    chk("t4_secs", 32'(secs_left), 3);
    chk("t4_no_exp", 32'(expired), 0);
    chk("t4_warn0", 32'(warn), 0);
    chk("t4_busy", 32'(busy), 1);
    cyc();
    chk("t4_no_exp2", 32'(expired), 0);
    cancel = 1'b1;
    cyc();
    cancel = 1'b0;

    // 5: cancel beats pay_ok; pay_ok alone pulses paid
    do_start();
    mtick();
    chk("t5_at4", 32'(secs_left), 4);
    pay_ok = 1'b1;
    cancel = 1'b1;
    cyc();
    pay_ok = 1'b0;
    cancel = 1'b0;
    chk_idle("t5_cancel");
    do_start();
    pay_ok = 1'b1;
    cyc();
    pay_ok = 1'b0;
    chk("t5_paid", 32'(paid), 1);
    chk("t5_paid_busy", 32'(busy), 0);
    chk("t5_paid_secs", 32'(secs_left), 0);
    cyc();
    chk("t5_paid_once", 32'(paid), 0);

    // 6: held tick counts once; start ignored in COUNT and EXPIRED
    do_start();
    man_tick = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("t6_held", 32'(secs_left), 4);
    end
    man_tick = 1'b0;
    cyc();
    do_start();
    chk("t6_start_cnt", 32'(secs_left), 4);
    chk("t6_start_busy", 32'(busy), 1);
    repeat (3) mtick();
    chk("t6_at1", 32'(secs_left), 1);
    man_tick = 1'b1;
    cyc();
    man_tick = 1'b0;
    chk("t6_expired", 32'(expired), 1);
    chk("t6_exp_tick_en", 32'(tick_en), 0);
    start = 1'b1;
    coin_evt = 1'b1;
    cancel = 1'b1;
    cyc();
    start = 1'b0;
    coin_evt = 1'b0;
    cancel = 1'b0;
    chk_idle("t6_post_exp");
    cyc();
    chk("t6_still_idle", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
